cmdregs: RTL and testbench

- Register bank directly downstream of the SPI command slave (`cmdspi`).
- Consumes its single-cycle write strobe, 7-bit address and 32-bit write data.
- Returns 32-bit read data, which the SPI slave samples one clock after the address settles.
- Provides DSP control words, status readback, sticky event capture with an interrupt, and self-clearing strobes.

---
 rtl/cmdregs_pkg.sv | 26 ++
 rtl/cmdregs_evt.sv | 73 +++++++
 rtl/cmdregs.sv | 203 ++++++++++++++++++++
 tb/tb_cmdregs.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmdregs_pkg.sv
// cmdregs_pkg: address map and small helpers shared by the cmdregs register bank.
package cmdregs_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_ID         = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_SCRATCH    = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EVT_STATUS = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EVT_MASK   = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_STROBE     = 7'h04;
   localparam logic [ADDR_W-1:0] ADDR_WR_COUNT   = 7'h05;
   localparam logic [ADDR_W-1:0] ADDR_CTRL_BASE  = 7'h10;
   localparam logic [ADDR_W-1:0] ADDR_STAT_BASE  = 7'h20;

   // STROBE bit that doubles as the shadow commit when shadowing is built in.
   localparam int unsigned COMMIT_BIT = 31;

   // True when address a selects word k of the window starting at base.
   function automatic logic word_sel(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       k);
      return a == (base + ADDR_W'(k));
   endfunction

endpackage

// File: rtl/cmdregs_evt.sv
// cmdregs_evt: rising-edge capture of 32 event lines into a sticky W1C status
// register, an RW mask, and a registered interrupt from status & mask.
module cmdregs_evt
   import cmdregs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] evt,
   input  logic              status_wr,
   input  logic              mask_wr,
   input  logic [DATA_W-1:0] wdat,
   output logic [DATA_W-1:0] status,
   output logic [DATA_W-1:0] mask,
   output logic              irq
);

   logic [DATA_W-1:0] evt_d;
   logic [DATA_W-1:0] status_q;
   logic [DATA_W-1:0] status_d;
   logic [DATA_W-1:0] mask_q;
   logic [DATA_W-1:0] rise;
   logic [DATA_W-1:0] clr;
   logic              irq_q;

   // Next status: W1C clear first, then new edges, so a same-cycle set wins.
   always_comb begin
      rise     = evt & ~evt_d;
      clr      = status_wr ? wdat : '0;
      status_d = (status_q & ~clr) | rise;
   end

   // Previous-cycle copy of the event lines; reset to 0 so a line held high
   // through reset registers as an edge on the first cycle after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt_d <= '0;
      end else begin
         evt_d <= evt;
      end
   end

   // Sticky status register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

   // Interrupt mask.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
      end else if (mask_wr) begin
         mask_q <= wdat;
      end
   end

   // Registered interrupt; lags any status or mask change by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(status_q & mask_q);
      end
   end

   assign status = status_q;
   assign mask   = mask_q;
   assign irq    = irq_q;

endmodule

// File: rtl/cmdregs.sv
// cmdregs: register bank behind the cmdspi command slave. Provides ID, scratch,
// sticky events with interrupt, self-clearing strobes, a write counter, CTRL
// words and a registered STAT snapshot. Read data is combinational from addr.
// Build option CMDREGS_SHADOW_EN: CTRL writes land in shadow registers that are
// copied to ctrl_o together when STROBE is written with bit 31 set.
module cmdregs
   import cmdregs_pkg::*;
#(
   parameter int unsigned N_CTRL   = 8,
   parameter int unsigned N_STAT   = 8,
   parameter logic [31:0] ID_VALUE = 32'hC0DE0001
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wdat,
   output logic [DATA_W-1:0]        rdat,
   output logic [DATA_W*N_CTRL-1:0] ctrl_o,
   input  logic [DATA_W*N_STAT-1:0] stat_i,
   input  logic [DATA_W-1:0]        evt_i,
   output logic [DATA_W-1:0]        strobe_o,
   output logic                     irq_o
);

   logic              wr_scratch;
   logic              wr_evt_status;
   logic              wr_evt_mask;
   logic              wr_strobe;
   logic [N_CTRL-1:0] wr_ctrl;

   logic [DATA_W-1:0] scratch_q;
   logic [DATA_W-1:0] strobe_q;
   logic [DATA_W-1:0] wr_count_q;
   logic [DATA_W-1:0] ctrl_q  [N_CTRL];
   logic [DATA_W-1:0] ctrl_rd [N_CTRL];
   logic [DATA_W-1:0] stat_q  [N_STAT];
   logic [DATA_W-1:0] evt_status;
   logic [DATA_W-1:0] evt_mask;

   // Write decode; CTRL words beyond N_CTRL never match and are dropped.
   always_comb begin
      wr_scratch    = we && (addr == ADDR_SCRATCH);
      wr_evt_status = we && (addr == ADDR_EVT_STATUS);
      wr_evt_mask   = we && (addr == ADDR_EVT_MASK);
      wr_strobe     = we && (addr == ADDR_STROBE);
      wr_ctrl       = '0;
      for (int unsigned k = 0; k < N_CTRL; k++) begin
         wr_ctrl[k] = we && word_sel(addr, ADDR_CTRL_BASE, k);
      end
   end

   // Scratch register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scratch_q <= '0;
      end else if (wr_scratch) begin
         scratch_q <= wdat;
      end
   end

   // Strobes: a write pulses for exactly the next cycle; back-to-back writes
   // give back-to-back pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strobe_q <= '0;
      end else begin
         strobe_q <= wr_strobe ? wdat : '0;
      end
   end

   // Count of write cycles to any address, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count_q <= '0;
      end else if (we) begin
         wr_count_q <= wr_count_q + 32'd1;
      end
   end

`ifdef CMDREGS_SHADOW_EN
   logic [DATA_W-1:0] shadow_q [N_CTRL];
   logic              commit;

   assign commit = wr_strobe && wdat[COMMIT_BIT];

   // CTRL writes land in the shadows only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            if (wr_ctrl[k]) begin
               shadow_q[k] <= wdat;
            end
         end
      end
   end

   // Commit copies every shadow to the live words at once, in step with the
   // strobe_o[31] pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            ctrl_q[k] <= '0;
         end
      end else if (commit) begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            ctrl_q[k] <= shadow_q[k];
         end
      end
   end

   // Software reads back the pending shadow values.
   always_comb begin
      for (int unsigned k = 0; k < N_CTRL; k++) begin
         ctrl_rd[k] = shadow_q[k];
      end
   end
`else
   // CTRL writes drive the live words directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            ctrl_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < N_CTRL; k++) begin
            if (wr_ctrl[k]) begin
               ctrl_q[k] <= wdat;
            end
         end
      end
   end

   // Readback is the live value.
   always_comb begin
      for (int unsigned k = 0; k < N_CTRL; k++) begin
         ctrl_rd[k] = ctrl_q[k];
      end
   end
`endif

   // Whole-word snapshot of stat_i every cycle so a read is coherent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_STAT; k++) begin
            stat_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < N_STAT; k++) begin
            stat_q[k] <= stat_i[DATA_W*k +: DATA_W];
         end
      end
   end

   cmdregs_evt u_evt (
      .clk       (clk),
      .rst       (rst),
      .evt       (evt_i),
      .status_wr (wr_evt_status),
      .mask_wr   (wr_evt_mask),
      .wdat      (wdat),
      .status    (evt_status),
      .mask      (evt_mask),
      .irq       (irq_o)
   );

   // Pack the live CTRL words onto the flat output bus.
   always_comb begin
      ctrl_o = '0;
      for (int unsigned k = 0; k < N_CTRL; k++) begin
         ctrl_o[DATA_W*k +: DATA_W] = ctrl_q[k];
      end
   end

   assign strobe_o = strobe_q;

   // Read mux: combinational, the SPI slave samples it one clock later.
   always_comb begin
      case (addr)
         ADDR_ID:         rdat = ID_VALUE;
         ADDR_SCRATCH:    rdat = scratch_q;
         ADDR_EVT_STATUS: rdat = evt_status;
         ADDR_EVT_MASK:   rdat = evt_mask;
         ADDR_WR_COUNT:   rdat = wr_count_q;
         default:         rdat = '0;
      endcase
      for (int unsigned k = 0; k < N_CTRL; k++) begin
         if (word_sel(addr, ADDR_CTRL_BASE, k)) begin
            rdat = ctrl_rd[k];
         end
      end
      for (int unsigned k = 0; k < N_STAT; k++) begin
         if (word_sel(addr, ADDR_STAT_BASE, k)) begin
            rdat = stat_q[k];
         end
      end
   end

endmodule

// File: tb/tb_cmdregs.sv
// tb_cmdregs: scenario tasks for the cmdregs register bank; expected values are
// queued when stimulus is driven and popped when the output is sampled.
module tb_cmdregs;
   import cmdregs_pkg::*;

   localparam int unsigned NC = 8;
   localparam int unsigned NS = 8;
   localparam logic [31:0] ID = 32'hC0DE0001;

   logic              clk    = 1'b0;
   logic              rst    = 1'b1;
   logic              we     = 1'b0;
   logic [6:0]        addr   = '0;
   logic [31:0]       wdat   = '0;
   logic [31:0]       rdat;
   logic [32*NC-1:0]  ctrl_o;
   logic [32*NS-1:0]  stat_i = '0;
   logic [31:0]       evt_i  = '0;
   logic [31:0]       strobe_o;
   logic              irq_o;

   int          n_tests   = 0;
   int          n_fail    = 0;
   logic [31:0] model_cnt = '0;
   logic [31:0] exp_q [$];
   logic [31:0] got;
   logic [31:0] exp_v;

   cmdregs #(
      .N_CTRL   (NC),
      .N_STAT   (NS),
      .ID_VALUE (ID)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .addr     (addr),
      .wdat     (wdat),
      .rdat     (rdat),
      .ctrl_o   (ctrl_o),
      .stat_i   (stat_i),
      .evt_i    (evt_i),
      .strobe_o (strobe_o),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;

   // One write cycle: called between edges, returns at the next negedge.
   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdat = d;
      @(negedge clk);
      we = 1'b0;
      model_cnt = model_cnt + 32'd1;
   endtask

   task automatic rd(input logic [6:0] a);
      addr = a;
      #1 got = rdat;
   endtask

   task automatic test_reset();
      logic [6:0] ra [4];
      ra = '{7'h00, 7'h01, 7'h10, 7'h7F};
      evt_i = 32'h1;  // held high through reset
      #1 rst = 1'b0;
      model_cnt = '0;
      #1;
      exp_q.push_back(ID); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      for (int i = 0; i < 4; i++) begin
         rd(ra[i]); exp_v = exp_q.pop_front(); n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL reset_rd[%h]: got %h want %h", ra[i], got, exp_v); end
      end
      n_tests++;
      if (ctrl_o !== '0) begin n_fail++; $display("FAIL reset_ctrl_o: got %h want 0", ctrl_o); end
      n_tests++;
      if (strobe_o !== '0 || irq_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got strobe %h irq %b want 0 0", strobe_o, irq_o);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      exp_q.push_back(32'h1); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL evt_held_through_reset: got %h want %h", got, exp_v); end
      evt_i = '0;
      wr(ADDR_EVT_STATUS, 32'h1);
      exp_q.push_back(32'h0); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL evt_w1c_after_reset: got %h want %h", got, exp_v); end
   endtask

   task automatic test_scratch();
      wr(ADDR_SCRATCH, 32'h1111_1111);
      exp_q.push_back(32'h1111_1111); rd(ADDR_SCRATCH); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL scratch_rw: got %h want %h", got, exp_v); end
      // write and read the same address in one cycle: old value visible
      we = 1'b1; addr = ADDR_SCRATCH; wdat = 32'h2222_2222; exp_q.push_back(32'h1111_1111);
      #1 got = rdat; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL scratch_same_cycle: got %h want %h", got, exp_v); end
      @(negedge clk); we = 1'b0; model_cnt = model_cnt + 32'd1;
      exp_q.push_back(32'h2222_2222); rd(ADDR_SCRATCH); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL scratch_new: got %h want %h", got, exp_v); end
      wr(ADDR_ID, 32'h0); wr(7'h06, 32'hFFFF_FFFF);
      exp_q.push_back(ID); rd(ADDR_ID); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL id_read_only: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); rd(7'h06); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL unmapped_reads_zero: got %h want %h", got, exp_v); end
   endtask

   task automatic test_ctrl();
      wr(7'h10, 32'hDEAD_BEEF);
`ifdef CMDREGS_SHADOW_EN
      exp_q.push_back(32'h0);
`else
      exp_q.push_back(32'hDEAD_BEEF);
`endif
      got = ctrl_o[31:0]; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl_o_after_write: got %h want %h", got, exp_v); end
      wr(7'h17, 32'hA5A5_0007);
      wr(7'h18, 32'h0000_0055);
`ifdef CMDREGS_SHADOW_EN
      wr(ADDR_STROBE, 32'h8000_0000);
`endif
      exp_q.push_back(32'hDEAD_BEEF); got = ctrl_o[31:0]; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl0_out: got %h want %h", got, exp_v); end
      exp_q.push_back(32'hA5A5_0007); got = ctrl_o[255:224]; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl7_out: got %h want %h", got, exp_v); end
      n_tests++;
      if (ctrl_o[223:32] !== '0) begin n_fail++; $display("FAIL ctrl_mid_words: got %h want 0", ctrl_o[223:32]); end
      exp_q.push_back(32'hDEAD_BEEF); rd(7'h10); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl0_rd: got %h want %h", got, exp_v); end
      exp_q.push_back(32'hA5A5_0007); rd(7'h17); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl7_rd: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); rd(7'h18); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ctrl_out_of_range: got %h want %h", got, exp_v); end
   endtask

`ifdef CMDREGS_SHADOW_EN
   task automatic test_shadow();
      wr(7'h10, 32'h0000_1234);
      exp_q.push_back(32'hDEAD_BEEF); got = ctrl_o[31:0]; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL shadow_ctrl_o_held: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0000_1234); rd(7'h10); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL shadow_readback: got %h want %h", got, exp_v); end
      wr(ADDR_STROBE, 32'h8000_0000);
      exp_q.push_back(32'h0000_1234); got = ctrl_o[31:0]; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL shadow_commit: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h8000_0000); got = strobe_o; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL shadow_commit_strobe: got %h want %h", got, exp_v); end
   endtask
`endif

   task automatic test_stat();
      stat_i[32*2 +: 32] = 32'hCAFE_F00D;
      stat_i[32*7 +: 32] = 32'h0000_7777;
      exp_q.push_back(32'h0); rd(7'h22); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stat_one_cycle_old: got %h want %h", got, exp_v); end
      @(negedge clk);
      exp_q.push_back(32'hCAFE_F00D); rd(7'h22); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stat2_rd: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0000_7777); rd(7'h27); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stat7_rd: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); rd(7'h28); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stat_out_of_range: got %h want %h", got, exp_v); end
      wr(7'h22, 32'hFFFF_FFFF);
      exp_q.push_back(32'hCAFE_F00D); rd(7'h22); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stat_read_only: got %h want %h", got, exp_v); end
   endtask

   task automatic test_evt();
      wr(ADDR_EVT_MASK, 32'h8);
      exp_q.push_back(32'h8); rd(ADDR_EVT_MASK); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL evt_mask_rd: got %h want %h", got, exp_v); end
      evt_i = 32'h8;  // one-cycle pulse
      @(negedge clk); evt_i = '0;
      exp_q.push_back(32'h8); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL evt_sticky_set: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_lags_status: got %h want %h", got, exp_v); end
      @(negedge clk);
      exp_q.push_back(32'h1); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_set: got %h want %h", got, exp_v); end
      // new edge on bit 3 in the same cycle as its W1C: set wins
      evt_i = 32'h8; we = 1'b1; addr = ADDR_EVT_STATUS; wdat = 32'h8;
      @(negedge clk); we = 1'b0; evt_i = '0; model_cnt = model_cnt + 32'd1;
      exp_q.push_back(32'h8); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL set_beats_clear: got %h want %h", got, exp_v); end
      wr(ADDR_EVT_STATUS, 32'h8);
      exp_q.push_back(32'h0); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL w1c_clears: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h1); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_lags_clear: got %h want %h", got, exp_v); end
      @(negedge clk);
      exp_q.push_back(32'h0); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_drop: got %h want %h", got, exp_v); end
      // a masked-off event is captured but raises no interrupt
      evt_i = 32'h10;
      @(negedge clk); evt_i = '0;
      @(negedge clk);
      exp_q.push_back(32'h10); rd(ADDR_EVT_STATUS); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL evt_masked_capture: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_masked: got %h want %h", got, exp_v); end
      wr(ADDR_EVT_STATUS, 32'h10);
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = model_cnt;
      exp_q.push_back(base); rd(ADDR_WR_COUNT); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL wr_count_before: got %h want %h", got, exp_v); end
      we = 1'b1; addr = ADDR_STROBE; wdat = 32'h5;
      exp_q.push_back(32'h5); exp_q.push_back(32'h5); exp_q.push_back(32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 1) we = 1'b0;
         got = strobe_o; exp_v = exp_q.pop_front(); n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL strobe_cycle%0d: got %h want %h", i, got, exp_v); end
      end
      model_cnt = model_cnt + 32'd2;
      exp_q.push_back(base + 32'd2); rd(ADDR_WR_COUNT); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL wr_count_plus2: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); rd(ADDR_STROBE); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL strobe_reads_zero: got %h want %h", got, exp_v); end
   endtask

   task automatic test_wrap();
      force dut.wr_count_q = 32'hFFFF_FFFE;
      #1 release dut.wr_count_q;
      wr(ADDR_SCRATCH, 32'h1); wr(ADDR_SCRATCH, 32'h2); wr(ADDR_SCRATCH, 32'h3);
      model_cnt = 32'h1;
      exp_q.push_back(32'h1); rd(ADDR_WR_COUNT); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL wr_count_wrap: got %h want %h", got, exp_v); end
   endtask

   task automatic test_async_reset();
      logic [6:0] ra [7];
      ra = '{ADDR_SCRATCH, ADDR_EVT_STATUS, ADDR_EVT_MASK, ADDR_WR_COUNT, 7'h10, 7'h17, 7'h22};
      wr(ADDR_EVT_MASK, 32'h1);
      evt_i = 32'h1;
      @(negedge clk); evt_i = '0;
      @(negedge clk);
      exp_q.push_back(32'h1); got = {31'b0, irq_o}; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL irq_before_reset: got %h want %h", got, exp_v); end
      we = 1'b1; addr = ADDR_STROBE; wdat = 32'h0000_FFFF;
      @(posedge clk); #2;
      exp_q.push_back(32'h0000_FFFF); got = strobe_o; exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL strobe_before_reset: got %h want %h", got, exp_v); end
      // reset falls between clock edges; a write stays requested across it
      addr = ADDR_SCRATCH; wdat = 32'h0BAD_0BAD;
      rst = 1'b0;
      #1;
      n_tests++;
      if (strobe_o !== '0 || irq_o !== 1'b0 || ctrl_o !== '0) begin
         n_fail++; $display("FAIL async_reset_outputs: got strobe %h irq %b ctrl %h want 0", strobe_o, irq_o, ctrl_o);
      end
      for (int i = 0; i < 7; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 7; i++) begin
         rd(ra[i]); exp_v = exp_q.pop_front(); n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_rd[%h]: got %h want %h", ra[i], got, exp_v); end
      end
      addr = ADDR_SCRATCH;
      @(negedge clk); we = 1'b0; rst = 1'b1; model_cnt = '0;
      @(negedge clk);
      exp_q.push_back(32'h0); rd(ADDR_SCRATCH); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL write_lost_in_reset: got %h want %h", got, exp_v); end
      exp_q.push_back(32'h0); rd(ADDR_WR_COUNT); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL wr_count_after_reset: got %h want %h", got, exp_v); end
      exp_q.push_back(ID); rd(ADDR_ID); exp_v = exp_q.pop_front(); n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL id_after_reset: got %h want %h", got, exp_v); end
   endtask

   initial begin
      test_reset();
      test_scratch();
      test_ctrl();
`ifdef CMDREGS_SHADOW_EN
      test_shadow();
`endif
      test_stat();
      test_evt();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
